apb_requester: RTL



---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_watchdog.sv | 37 +++
 rtl/apb_requester.sv | 124 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states, strobe width and the
// watchdog counter sizing helper.
`timescale 1ns/1ps

package apb_pkg;

    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

    // Counter must hold TIMEOUT_CYCLES-1; a disabled watchdog still needs one bit.
    function automatic int wd_count_width(input int timeout_cycles);
        return (timeout_cycles <= 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/apb_watchdog.sv
// Counts ACCESS cycles and flags the cycle on which a stalled transfer
// must be forcibly terminated. TIMEOUT_CYCLES = 0 disables it.
`timescale 1ns/1ps

module apb_watchdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic pclk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = wd_count_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge pclk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LAST_COUNT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count == LAST_COUNT);

endmodule

// File: rtl/apb_requester.sv
// Turns a single-outstanding core load/store into an APB SETUP/ACCESS
// transfer and returns a one-cycle registered response.
`timescale 1ns/1ps

module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  pclk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_write,
    input  logic [APB_STRB_W-1:0] req_strb,

    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_STRB_W-1:0] pstb,
    input  logic                  pready,
    input  logic                  perr
);

    apb_state_t state;
    apb_state_t state_next;

    logic expired;
    logic complete;
    logic finish;
    logic finish_err;

    // An unmapped address reports perr without pready, so perr alone must end the transfer.
    assign complete   = pready | perr | expired;
    assign finish     = (state == APB_ACCESS) && complete;
    assign finish_err = perr | (expired & ~pready);

    apb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .pclk     (pclk),
        .rst      (rst),
        .clear    (state == APB_SETUP),
        .count_en ((state == APB_ACCESS) && !complete),
        .expired  (expired)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= APB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            APB_IDLE:   if (req_valid) state_next = APB_SETUP;
            APB_SETUP:  state_next = APB_ACCESS;
            APB_ACCESS: if (complete) state_next = APB_IDLE;
            default:    state_next = APB_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        unique case (state)
            APB_IDLE:   req_ready = 1'b1;
            APB_SETUP:  psel = 1'b1;
            APB_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default:    req_ready = 1'b0;
        endcase
    end

    // Bus fields load only on accept, so they stay stable through ACCESS and idle at their last value.
    always_ff @(posedge pclk) begin
        if (rst) begin
            paddr  <= '0;
            pdata  <= '0;
            pwrite <= 1'b0;
            pstb   <= '0;
        end else if ((state == APB_IDLE) && req_valid) begin
            paddr  <= req_addr;
            pdata  <= req_wdata;
            pwrite <= req_write;
            pstb   <= req_write ? req_strb : '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= finish;
            if (finish) begin
                resp_err   <= finish_err;
                resp_rdata <= (!pwrite && !finish_err) ? prdata : '0;
            end
        end
    end

endmodule
